// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Iterative unsigned multiply/divide unit placed behind the register-file
//   read ports. One operation is accepted from IDLE, iterated for WIDTH
//   cycles in CALC, and announced with a single-cycle DONE in FIN.
//   A divide by zero skips CALC and completes on the cycle after acceptance.
//
// Ports
//   CLK      in   system clock, all state changes on the rising edge
//   RESET    in   asynchronous, active-high reset
//   START    in   operation request, sampled only in IDLE
//   OP       in   00 MUL (low word), 01 MULHU (high word),
//                 10 DIVU (quotient), 11 REMU (remainder)
//   DATA1    in   operand A / dividend
//   DATA2    in   operand B / divisor
//   RESULT   out  registered result, holds until the next completion or reset
//   BUSY     out  high while iterating
//   DONE     out  one-cycle completion pulse
//   DIVZERO  out  set with DONE when a DIVU/REMU divisor was zero
// -----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIVZERO
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand for MUL*, divisor for DIV*
    logic [2*WIDTH-1:0] r_prod;     // {partial sum, remaining multiplier bits}
    logic [WIDTH-1:0]   r_rem;      // partial remainder (always < divisor)
    logic [WIDTH-1:0]   r_quo;      // dividend bits shifting out, quotient bits in
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;
    logic               r_divzero;

    logic               w_accept;
    logic               w_divzero_req;
    logic               w_last;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH:0]     w_rem_diff;
    logic               w_sub_ok;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_calc_result;

    assign w_accept      = (r_state == S_IDLE) && START;
    assign w_divzero_req = OP[1] && (DATA2 == '0);
    assign w_last        = (r_cnt == CW'(WIDTH - 1));

    // Shift-add step: add the multiplicand to the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right by one.
    // The carry out of the add lands in the top bit after the shift.
    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                       + (r_prod[0] ? {1'b0, r_opnd} : '0);
    assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};

    // Restoring step: the shifted remainder is below twice the divisor, so the
    // WIDTH+1-bit difference never overflows and its MSB is the borrow.
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_opnd};
    assign w_sub_ok    = ~w_rem_diff[WIDTH];
    assign w_rem_next  = w_sub_ok ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], w_sub_ok};

    always_comb begin
        w_calc_result = w_prod_next[WIDTH-1:0];
        case (r_op)
            2'b00:   w_calc_result = w_prod_next[WIDTH-1:0];
            2'b01:   w_calc_result = w_prod_next[2*WIDTH-1:WIDTH];
            2'b10:   w_calc_result = w_quo_next;
            default: w_calc_result = w_rem_next;
        endcase
    end

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (START) w_next_state = w_divzero_req ? S_FIN : S_CALC;
            S_CALC: if (w_last) w_next_state = S_FIN;
            S_FIN:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_op      <= '0;
            r_opnd    <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= OP;
                r_opnd    <= OP[1] ? DATA2 : DATA1;
                r_prod    <= {{WIDTH{1'b0}}, DATA2};
                r_rem     <= '0;
                r_quo     <= DATA1;
                r_cnt     <= '0;
                r_divzero <= w_divzero_req;
                // A zero divisor completes immediately with the defined result.
                if (w_divzero_req) r_result <= OP[0] ? DATA1 : '1;
            end else if (r_state == S_CALC) begin
                r_prod <= w_prod_next;
                r_rem  <= w_rem_next;
                r_quo  <= w_quo_next;
                r_cnt  <= r_cnt + CW'(1);
                if (w_last) r_result <= w_calc_result;
            end
            // Status flags are registered from the next state so they line up
            // with the state register and never see the inputs directly.
            r_busy <= (w_next_state == S_CALC);
            r_done <= (w_next_state == S_FIN);
        end
    end

    assign RESULT  = r_result;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign DIVZERO = r_divzero;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Self-checking bench for mul_div_unit. Expected results come from plain
//   64-bit multiplication and the / and % operators, with the zero-divisor
//   results written out directly.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int W       = 32;
    localparam int LAT     = W;    // accept edge to DONE, in cycles
    localparam int TIMEOUT = 60;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         START;
    logic [1:0]   OP;
    logic [W-1:0] DATA1;
    logic [W-1:0] DATA2;
    logic [W-1:0] RESULT;
    logic         BUSY;
    logic         DONE;
    logic         DIVZERO;

    int n_vec  = 0;
    int n_miss = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .OP      (OP),
        .DATA1   (DATA1),
        .DATA2   (DATA2),
        .RESULT  (RESULT),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .DIVZERO (DIVZERO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_result(input logic [1:0] op,
                                                 input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (b == 0) ? '1 : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Counts negedges from the one after the accept edge until DONE is seen.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (DONE) return;
            if (BUSY) busy_cyc++;
            lat++;
            @(negedge CLK);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        int          lat;
        int          busy_cyc;
        logic        dz;
        logic [W-1:0] exp;
        dz  = op[1] && (b == 0);
        exp = ref_result(op, a, b);
        @(negedge CLK);
        START = 1'b1;
        OP    = op;
        DATA1 = a;
        DATA2 = b;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        // Operands changing after acceptance must not matter.
        DATA1 = $urandom;
        DATA2 = $urandom;
        OP    = 2'($urandom);
        check({tag, " divzero@accept"}, W'(DIVZERO), W'(dz));
        wait_done(lat, busy_cyc);
        check({tag, " latency"}, W'(lat), dz ? 0 : LAT);
        check({tag, " busy cycles"}, W'(busy_cyc), dz ? 0 : LAT);
        check({tag, " result"}, RESULT, exp);
        check({tag, " divzero"}, W'(DIVZERO), W'(dz));
        @(negedge CLK);
        check({tag, " done pulse width"}, W'(DONE), 0);
        check({tag, " result held"}, RESULT, exp);
    endtask

    initial begin
        int lat;
        int busy_cyc;
        int extra;
        START = 1'b0;
        OP    = 2'b00;
        DATA1 = '0;
        DATA2 = '0;
        RESET = 1'b0;
        #1 RESET = 1'b1;
        #2;
        check("reset RESULT", RESULT, 0);
        check("reset BUSY", W'(BUSY), 0);
        check("reset DONE", W'(DONE), 0);
        check("reset DIVZERO", W'(DIVZERO), 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // Directed cases
        run_op("mul 7x6",       2'b00, 32'd7,          32'd6);
        run_op("mulhu max",     2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op("mul max",       2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op("divu 100/7",    2'b10, 32'd100,        32'd7);
        run_op("remu 100/7",    2'b11, 32'd100,        32'd7);
        run_op("divu msb/1",    2'b10, 32'h8000_0000,  32'd1);
        run_op("remu 3/10",     2'b11, 32'd3,          32'd10);
        run_op("divu 5/0",      2'b10, 32'd5,          32'd0);
        run_op("remu 5/0",      2'b11, 32'd5,          32'd0);
        run_op("mul 2x3",       2'b00, 32'd2,          32'd3);
        run_op("divu max/max",  2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op("remu max/msb",  2'b11, 32'hFFFF_FFFF,  32'h8000_0000);

        // Randomized operations, with an occasional zero divisor
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 2'($urandom_range(3));
            a  = $urandom;
            b  = ($urandom_range(7) == 0) ? '0 : ($urandom_range(1) == 0 ? $urandom : W'($urandom_range(1000)));
            run_op($sformatf("rand%0d op%0d", i, op), op, a, b);
        end

        // START while busy is ignored; START held high re-accepts after FIN
        @(negedge CLK);
        START = 1'b1;
        OP    = 2'b00;
        DATA1 = 32'd3;
        DATA2 = 32'd4;
        @(posedge CLK);
        repeat (5) @(negedge CLK);
        OP    = 2'b10;
        DATA1 = 32'd9;
        DATA2 = 32'd3;
        wait_done(lat, busy_cyc);
        lat += 4;
        check("busy-ignore latency", W'(lat), LAT);
        check("busy-ignore result", RESULT, 32'd12);
        @(negedge CLK);
        check("b2b idle done", W'(DONE), 0);
        check("b2b idle busy", W'(BUSY), 0);
        @(negedge CLK);
        check("b2b reaccept busy", W'(BUSY), 1);
        START = 1'b0;
        wait_done(lat, busy_cyc);
        check("b2b latency", W'(lat), LAT);
        check("b2b result", RESULT, 32'd3);
        @(negedge CLK);

        // Reset in the middle of CALC aborts without a DONE
        START = 1'b1;
        OP    = 2'b00;
        DATA1 = 32'd5;
        DATA2 = 32'd5;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        check("pre-abort busy", W'(BUSY), 1);
        #2 RESET = 1'b1;
        #1;
        check("abort RESULT", RESULT, 0);
        check("abort BUSY", W'(BUSY), 0);
        check("abort DONE", W'(DONE), 0);
        check("abort DIVZERO", W'(DIVZERO), 0);
        @(negedge CLK);
        RESET = 1'b0;
        extra = 0;
        for (int i = 0; i < LAT + 8; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) extra++;
        end
        check("no done after abort", W'(extra), 0);
        run_op("mul 5x5 post-reset", 2'b00, 32'd5, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
